// File: rtl/score_tracker.sv
// Game score keeper: IDLE/RUN/OVER control, pipe-pass detection against the bird,
// saturating BCD score and a high score that survives restarts.
module score_tracker #(
   parameter int N_PIPES = 2,
   parameter int DIGITS  = 3,
   parameter int COORD_W = 11,
   parameter int PIPE_W  = 40
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         restart,
   input  logic                         collision,
   input  logic                         tick,
   input  logic [COORD_W-1:0]           bird_x,
   input  logic [N_PIPES*COORD_W-1:0]   pipe_x,
   output logic [4*DIGITS-1:0]          score_bcd,
   output logic [4*DIGITS-1:0]          high_bcd,
   output logic                         new_high,
   output logic                         running,
   output logic                         game_over
);

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   localparam int                  XW        = COORD_W + 1;
   localparam logic [XW-1:0]       PIPE_W_X  = XW'(PIPE_W);
   localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

   state_t                state, state_next;
   logic [COORD_W-1:0]    prev_x [N_PIPES];
   logic                  prev_valid;
   logic [N_PIPES-1:0]    pass;
   logic [XW-1:0]         bird_end;
   logic [4*DIGITS-1:0]   score_q, high_q, score_sum;
   logic                  new_high_q;
   logic                  enter_run, end_game, score_en;

   function automatic logic [3:0] popcount(input logic [N_PIPES-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int k = 0; k < N_PIPES; k++) c = c + {3'b000, v[k]};
      return c;
   endfunction

   // Ripple the increment through the digits; a carry out of the top digit saturates.
   function automatic logic [4*DIGITS-1:0] bcd_add(input logic [4*DIGITS-1:0] a,
                                                   input logic [3:0]          inc);
      logic [4*DIGITS-1:0] r;
      logic [4:0]          sum;
      logic [3:0]          carry;
      r     = '0;
      carry = inc;
      for (int d = 0; d < DIGITS; d++) begin
         sum = {1'b0, a[4*d +: 4]} + {1'b0, carry};
         if (sum > 5'd9) begin
            r[4*d +: 4] = 4'(sum - 5'd10);
            carry       = 4'd1;
         end else begin
            r[4*d +: 4] = sum[3:0];
            carry       = 4'd0;
         end
      end
      return (carry != 4'd0) ? ALL_NINES : r;
   endfunction

   // Right edges are compared one bit wider so positions near the screen edge cannot wrap.
   assign bird_end = {1'b0, bird_x};

   for (genvar i = 0; i < N_PIPES; i++) begin : g_pipe
      logic [COORD_W-1:0] cur_x;
      logic [XW-1:0]      cur_end, prev_end;
      assign cur_x    = pipe_x[i*COORD_W +: COORD_W];
      assign cur_end  = {1'b0, cur_x} + PIPE_W_X;
      assign prev_end = {1'b0, prev_x[i]} + PIPE_W_X;
      assign pass[i]  = prev_valid && (prev_end > bird_end) && (cur_end <= bird_end)
                        && (cur_x <= prev_x[i]);
   end

   assign enter_run = (state == IDLE) && start;
   assign end_game  = (state == RUN) && collision;
   assign score_en  = (state == RUN) && tick && !collision;
   assign score_sum = bcd_add(score_q, popcount(pass));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: defaulting state_next first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      if (restart) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (collision) state_next = OVER;
            default: state_next = state;
         endcase
      end
   end

   always_comb begin
      running   = (state == RUN);
      game_over = (state == OVER);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         score_q    <= '0;
         high_q     <= '0;
         new_high_q <= 1'b0;
      end else if (restart) begin
         score_q    <= '0;
         new_high_q <= 1'b0;
      end else if (end_game) begin
         if (score_q > high_q) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
         end
      end else if (score_en) begin
         score_q <= score_sum;
      end
   end

   // NOTE: prev_x is a small register array with a defined reset value, not a RAM, so it is reset here.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_valid <= 1'b0;
         for (int k = 0; k < N_PIPES; k++) prev_x[k] <= '0;
      end else begin
         if (tick) begin
            for (int k = 0; k < N_PIPES; k++) prev_x[k] <= pipe_x[k*COORD_W +: COORD_W];
         end
         if (restart || enter_run) prev_valid <= 1'b0;
         else if (tick)            prev_valid <= 1'b1;
      end
   end

   assign score_bcd = score_q;
   assign high_bcd  = high_q;
   assign new_high  = new_high_q;

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have parameter N_PIPES, default 2, number of pipe channels monitored (1..9).
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD digits in score and high score (1..8).
REQ-003 SHALL have parameter COORD_W, default 11, width of each screen coordinate.
REQ-004 SHALL have parameter PIPE_W, default 40, pipe width in pixels.
REQ-005 SHALL have port clock, input, 1, rising-edge system clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, begins a game from IDLE.
REQ-008 SHALL have port restart, input, 1, aborts or ends the current game and returns to IDLE.
REQ-009 SHALL have port collision, input, 1, bird hit a pipe or the ground.
REQ-010 SHALL have port tick, input, 1, one-cycle frame strobe; positions are valid on this cycle.
REQ-011 SHALL have port bird_x, input, COORD_W, bird left x.
REQ-012 SHALL have port pipe_x, input, N_PIPES*COORD_W, pipe i left x in bits [i*COORD_W +: COORD_W].
REQ-013 SHALL have port score_bcd, output, 4*DIGITS, current score, most-significant digit at top.
REQ-014 SHALL have port high_bcd, output, 4*DIGITS, high score.
REQ-015 SHALL have port new_high, output, 1, last game set a new high score.
REQ-016 SHALL have port running, output, 1, state == RUN.
REQ-017 SHALL have port game_over, output, 1, state == OVER.

Function
REQ-018 SHALL implement the states IDLE, RUN and OVER.
REQ-019 Transitions SHALL be: IDLE->RUN on start; RUN->OVER on collision; OVER->IDLE on restart.
REQ-020 restart SHALL take priority in every state: next state IDLE, score cleared, new_high cleared, high kept.
REQ-021 SHALL keep a per-pipe prev_x register and a prev_valid flag, both updated on every tick.
REQ-022 prev_valid SHALL be cleared on reset, on restart and on entry to RUN; the first tick after clearing only loads prev_x.
REQ-023 Pipe i pass SHALL be detected on tick with prev_valid=1 when prev_x[i]+PIPE_W > bird_x and pipe_x[i]+PIPE_W <= bird_x, computed at COORD_W+1 bits.
REQ-024 A pipe respawn (pipe_x > prev_x) SHALL never produce a pass.
REQ-025 Passes SHALL be counted only in RUN on a cycle with collision=0; a collision on the same cycle suppresses scoring.
REQ-026 Score SHALL increase by the popcount of passes, using a BCD add with digit carry, registered one cycle after the tick.
REQ-027 Score SHALL saturate at all-9s and never wrap.
REQ-028 On the RUN->OVER edge, if score > high_bcd (BCD magnitude compare), high_bcd SHALL load score and new_high SHALL be set to 1.
REQ-029 If score == high_bcd on that edge, high_bcd SHALL be unchanged and new_high SHALL stay 0.
REQ-030 new_high SHALL hold its value until restart or reset.
REQ-031 score_bcd SHALL hold its value in OVER and in IDLE.
REQ-032 start SHALL be ignored outside IDLE; collision SHALL be ignored outside RUN.

Reset
REQ-033 On reset the state SHALL be IDLE, with score_bcd=0, high_bcd=0, new_high=0, running=0, game_over=0, prev_valid=0 and prev_x=0.
REQ-034 reset SHALL override start, restart, collision and tick on the same cycle.

Verification (N_PIPES=2, DIGITS=3, COORD_W=11, PIPE_W=40)
REQ-035 Reset check: assert reset with all inputs active -> all outputs 0, state IDLE.
REQ-036 Single pass: start, bird_x=100, tick pipe0=70, then tick pipe0=59 -> score 001 one cycle after the second tick.
REQ-037 Dual pass: both pipes go 61->59 on the same tick -> score +2.
REQ-038 BCD carry and saturation: score 099 plus one pass -> 100; score 998 plus two passes -> 999; 999 plus one pass -> 999.
REQ-039 Game over: score 005, high 003, collision -> next cycle game_over=1, high 005, new_high=1; restart -> IDLE, score 000, high 005, new_high=0.
REQ-040 Non-scoring cases -> score unchanged for each of: pipe0 respawn 10->600; a qualifying tick in IDLE; a qualifying tick coincident with collision; a qualifying first tick after entering RUN.
